// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU opcodes, operand modes,
// MIPS primary opcode / funct encodings and the decoded control word.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b0110,
        ALU_GT  = 4'b0111,
        ALU_LT  = 4'b1000
    } alu_op_e;

    localparam logic [1:0] MODE_UNSIGNED = 2'b00;
    localparam logic [1:0] MODE_SIGNED   = 2'b01;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SGT  = 6'h2C;
    localparam logic [5:0] FN_SGTU = 6'h2D;

    // One decoded ALU control word as held in the issue FIFO
    typedef struct packed {
        alu_op_e     opcode;
        logic [1:0]  mode;
        logic [4:0]  shamt;
        logic        src_imm;
        logic        illegal;
    } alu_word_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS op/funct decoder producing one ALU control word.
// Unlisted encodings decode as unsigned add with the raw illegal flag set;
// the top decides whether that flag is honoured.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [5:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic [4:0] instr_shamt,
    output alu_word_t  word
);

    // Decode the opcode (and funct for R-type) into opcode/mode/shamt/source
    always_comb begin
        word.opcode  = ALU_ADD;
        word.mode    = MODE_UNSIGNED;
        word.shamt   = 5'd0;
        word.src_imm = 1'b0;
        word.illegal = 1'b0;
        if (instr_op == OP_RTYPE) begin
            case (instr_funct)
                FN_ADD:  begin word.opcode = ALU_ADD; word.mode = MODE_SIGNED; end
                FN_ADDU: word.opcode = ALU_ADD;
                FN_SUB:  begin word.opcode = ALU_SUB; word.mode = MODE_SIGNED; end
                FN_SUBU: word.opcode = ALU_SUB;
                FN_AND:  word.opcode = ALU_AND;
                FN_OR:   word.opcode = ALU_OR;
                FN_SLL:  begin word.opcode = ALU_SLL; word.shamt = instr_shamt; end
                FN_SRL:  begin word.opcode = ALU_SRL; word.shamt = instr_shamt; end
                FN_SRA:  begin word.opcode = ALU_SRA; word.shamt = instr_shamt; end
                FN_SLT:  begin word.opcode = ALU_LT;  word.mode = MODE_SIGNED; end
                FN_SLTU: word.opcode = ALU_LT;
                FN_SGT:  begin word.opcode = ALU_GT;  word.mode = MODE_SIGNED; end
                FN_SGTU: word.opcode = ALU_GT;
                default: word.illegal = 1'b1;
            endcase
        end else begin
            case (instr_op)
                OP_ADDI:  begin word.opcode = ALU_ADD; word.mode = MODE_SIGNED; word.src_imm = 1'b1; end
                OP_ADDIU: begin word.opcode = ALU_ADD; word.src_imm = 1'b1; end
                OP_ANDI:  begin word.opcode = ALU_AND; word.src_imm = 1'b1; end
                OP_ORI:   begin word.opcode = ALU_OR;  word.src_imm = 1'b1; end
                OP_SLTI:  begin word.opcode = ALU_LT;  word.mode = MODE_SIGNED; word.src_imm = 1'b1; end
                OP_SLTIU: begin word.opcode = ALU_LT;  word.src_imm = 1'b1; end
                OP_LW:    begin word.opcode = ALU_ADD; word.src_imm = 1'b1; end
                OP_SW:    begin word.opcode = ALU_ADD; word.src_imm = 1'b1; end
                OP_BEQ:   word.opcode = ALU_SUB;
                OP_BNE:   word.opcode = ALU_SUB;
                default:  word.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes MIPS instructions and buffers the resulting
// ALU control words in a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to report undecodable
// instructions on illegal / illegal_sticky; otherwise both are tied low.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic [4:0] instr_shamt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_opcode,
    output logic [1:0] alu_mode,
    output logic [4:0] alu_shamt,
    output logic       alu_src_imm,
    output logic       illegal,
    output logic       illegal_sticky,
    input  logic       clr_illegal
);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    alu_word_t  dec_word;
    alu_word_t  head_word;
    alu_word_t  mem_q [2];
    alu_word_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       ready_en_q, ready_en_d;
    logic       sticky_q, sticky_d;
    logic       push, pop, full;

    alu_issue_decode u_decode (
        .instr_op    (instr_op),
        .instr_funct (instr_funct),
        .instr_shamt (instr_shamt),
        .word        (dec_word)
    );

    // Handshakes and gated outputs; the FIFO head is only visible while valid
    always_comb begin
        full           = (count_q == 2'd2);
        in_ready       = ready_en_q & ~full;
        out_valid      = (count_q != 2'd0);
        push           = in_valid & in_ready;
        pop            = out_valid & out_ready;
        head_word      = mem_q[rd_ptr_q];
        alu_opcode     = out_valid ? head_word.opcode  : 4'd0;
        alu_mode       = out_valid ? head_word.mode    : 2'd0;
        alu_shamt      = out_valid ? head_word.shamt   : 5'd0;
        alu_src_imm    = out_valid ? head_word.src_imm : 1'b0;
        illegal        = out_valid & head_word.illegal & TRAP_EN;
        illegal_sticky = sticky_q & TRAP_EN;
    end

    // Next-state for FIFO storage, pointers, occupancy and sticky flag
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        sticky_d   = sticky_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (clr_illegal) begin
            sticky_d = 1'b0;
        end
        if (pop && head_word.illegal && TRAP_EN) begin
            sticky_d = 1'b1;
        end
    end

    // State registers; reset empties the FIFO and holds off in_ready until the first edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_en_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
            sticky_q   <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. Inputs change and outputs are
// sampled 1ns after each rising clock edge.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] instr_op;
    logic [5:0] instr_funct;
    logic [4:0] instr_shamt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_opcode;
    logic [1:0] alu_mode;
    logic [4:0] alu_shamt;
    logic       alu_src_imm;
    logic       illegal;
    logic       illegal_sticky;
    logic       clr_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr_op       (instr_op),
        .instr_funct    (instr_funct),
        .instr_shamt    (instr_shamt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_opcode     (alu_opcode),
        .alu_mode       (alu_mode),
        .alu_shamt      (alu_shamt),
        .alu_src_imm    (alu_src_imm),
        .illegal        (illegal),
        .illegal_sticky (illegal_sticky),
        .clr_illegal    (clr_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh);
        in_valid    = v;
        instr_op    = op;
        instr_funct = fn;
        instr_shamt = sh;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive(1'b0, 6'h00, 6'h00, 5'd0);
        out_ready = 1'b0; clr_illegal = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if ({alu_opcode, alu_mode, alu_shamt, alu_src_imm, illegal, illegal_sticky} !== 14'd0) begin
            bad++; $display("[TB] FAIL reset_ctrl_outputs got=%h want=0", {alu_opcode, alu_mode, alu_shamt, alu_src_imm, illegal, illegal_sticky});
        end
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_in_ready_before_edge got=%b want=0", in_ready); end
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    // Single-word transactions through an empty FIFO with out_ready held high
    task automatic test_decode();
        logic [5:0] ops   [8] = '{6'h00, 6'h00, 6'h0A, 6'h04, 6'h00, 6'h0C, 6'h23, 6'h00};
        logic [5:0] fns   [8] = '{6'h22, 6'h03, 6'h00, 6'h00, 6'h2D, 6'h00, 6'h00, 6'h00};
        logic [4:0] shs   [8] = '{5'd9,  5'd7,  5'd3,  5'd0,  5'd4,  5'd1,  5'd2,  5'd31};
        logic [3:0] e_op  [8] = '{4'h1,  4'h6,  4'h8,  4'h1,  4'h7,  4'h2,  4'h0,  4'h4};
        logic [1:0] e_md  [8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [4:0] e_sh  [8] = '{5'd0,  5'd7,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd31};
        logic       e_imm [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], fns[i], shs[i]);
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dec%0d_no_bypass got=%b want=0", i, out_valid); end
            step();
            drive(1'b0, 6'h00, 6'h00, 5'd0);
            total++; if ({out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm} !== {1'b1, e_op[i], e_md[i], e_sh[i], e_imm[i]}) begin
                bad++; $display("[TB] FAIL dec%0d_word got=%b_%b_%b_%b_%b want=1_%b_%b_%b_%b", i,
                    out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm, e_op[i], e_md[i], e_sh[i], e_imm[i]);
            end
            step();
            total++; if ({out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm} !== 13'd0) begin
                bad++; $display("[TB] FAIL dec%0d_idle_zero got=%b_%b_%b_%b_%b want=0", i,
                    out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm);
            end
        end
    endtask

    // Fill the FIFO with out_ready low, hold a third request, then drain in order
    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h22, 5'd0); step();
        drive(1'b1, 6'h00, 6'h24, 5'd0); step();
        total++; if ({in_ready, out_valid, alu_opcode, alu_mode} !== {1'b0, 1'b1, 4'h1, 2'b01}) begin
            bad++; $display("[TB] FAIL b2b_full got=%b_%b_%h_%b want=0_1_1_01", in_ready, out_valid, alu_opcode, alu_mode);
        end
        drive(1'b1, 6'h00, 6'h25, 5'd0); step(); step();
        total++; if ({in_ready, out_valid, alu_opcode, alu_mode} !== {1'b0, 1'b1, 4'h1, 2'b01}) begin
            bad++; $display("[TB] FAIL b2b_hold got=%b_%b_%h_%b want=0_1_1_01", in_ready, out_valid, alu_opcode, alu_mode);
        end
        out_ready = 1'b1;
        step();
        total++; if ({in_ready, out_valid, alu_opcode} !== {1'b1, 1'b1, 4'h2}) begin
            bad++; $display("[TB] FAIL b2b_second got=%b_%b_%h want=1_1_2", in_ready, out_valid, alu_opcode);
        end
        step();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        total++; if ({out_valid, alu_opcode} !== {1'b1, 4'h3}) begin
            bad++; $display("[TB] FAIL b2b_third got=%b_%h want=1_3", out_valid, alu_opcode);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    // One entry held, then push and pop together for 10 cycles using sll shamt as a tag
    task automatic test_push_pop();
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h00, 5'd1); step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 6'h00, 6'h00, 5'(i + 2));
            total++; if ({out_valid, in_ready, alu_opcode, alu_shamt} !== {1'b1, 1'b1, 4'h4, 5'(i + 1)}) begin
                bad++; $display("[TB] FAIL pp%0d got=%b_%b_%h_%0d want=1_1_4_%0d", i, out_valid, in_ready, alu_opcode, alu_shamt, i + 1);
            end
            step();
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        total++; if ({out_valid, alu_shamt} !== {1'b1, 5'd11}) begin
            bad++; $display("[TB] FAIL pp_last got=%b_%0d want=1_11", out_valid, alu_shamt);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pp_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        drive(1'b1, 6'h3F, 6'h00, 5'd5); step();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        total++; if ({out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm} !== {1'b1, 4'h0, 2'b00, 5'd0, 1'b0}) begin
            bad++; $display("[TB] FAIL ill_word got=%b_%h_%b_%0d_%b want=1_0_00_0_0", out_valid, alu_opcode, alu_mode, alu_shamt, alu_src_imm);
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        total++; if ({illegal, illegal_sticky} !== 2'b10) begin bad++; $display("[TB] FAIL ill_head got=%b want=10", {illegal, illegal_sticky}); end
        out_ready = 1'b1; step();
        total++; if ({out_valid, illegal, illegal_sticky} !== 3'b001) begin bad++; $display("[TB] FAIL ill_popped got=%b want=001", {out_valid, illegal, illegal_sticky}); end
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h3E, 5'd0); step();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        clr_illegal = 1'b1; out_ready = 1'b1; step();
        total++; if (illegal_sticky !== 1'b1) begin bad++; $display("[TB] FAIL ill_set_wins got=%b want=1", illegal_sticky); end
        step();
        clr_illegal = 1'b0;
        total++; if (illegal_sticky !== 1'b0) begin bad++; $display("[TB] FAIL ill_cleared got=%b want=0", illegal_sticky); end
`else
        total++; if ({illegal, illegal_sticky} !== 2'b00) begin bad++; $display("[TB] FAIL ill_head got=%b want=00", {illegal, illegal_sticky}); end
        out_ready = 1'b1; step();
        total++; if ({out_valid, illegal, illegal_sticky} !== 3'b000) begin bad++; $display("[TB] FAIL ill_popped got=%b want=000", {out_valid, illegal, illegal_sticky}); end
`endif
    endtask

    // Asynchronous reset with a full FIFO discards both words
    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h22, 5'd0); step();
        drive(1'b1, 6'h00, 6'h25, 5'd0); step();
        drive(1'b0, 6'h00, 6'h00, 5'd0);
        total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rst_pre got=%b want=10", {out_valid, in_ready}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, in_ready, alu_opcode, alu_mode} !== 8'd0) begin
            bad++; $display("[TB] FAIL rst_async got=%b_%b_%h_%b want=0_0_0_00", out_valid, in_ready, alu_opcode, alu_mode);
        end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        total++; if ({out_valid, in_ready, alu_opcode} !== {1'b0, 1'b1, 4'h0}) begin
            bad++; $display("[TB] FAIL rst_no_stale got=%b_%b_%h want=0_1_0", out_valid, in_ready, alu_opcode);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_stale_later got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_push_pop();
        test_illegal();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
